// File: rtl/miriscv_gpr_wb_ctrl.sv
// miriscv_gpr_wb_ctrl: GPR write-back arbiter (execute vs. LSU load response),
// pending-load scoreboard, outstanding-load counter and decode hazard detect.
// Latency: write grant is combinational (zero cycles); scoreboard/count update on the next edge.
// Backpressure: the losing requester sees ready=0 and must hold valid/addr/data; the
// conflict winner alternates round-robin. ld_full_o blocks new load issue.
// Ports: clk_i/arst_i; A (execute) and B (load response) valid/addr/data/ready;
//        ld_issue_i/ld_rd_i load issue; dec_* decode operands; hazard_o, ld_full_o;
//        wr_en_o/wr_addr_o/wr_data_o GPR write port.
module miriscv_gpr_wb_ctrl #(
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int LD_MAX         = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      a_valid_i,
  input  logic [GPR_ADDR_WIDTH-1:0] a_addr_i,
  input  logic [XLEN-1:0]           a_data_i,
  output logic                      a_ready_o,
  input  logic                      b_valid_i,
  input  logic [GPR_ADDR_WIDTH-1:0] b_addr_i,
  input  logic [XLEN-1:0]           b_data_i,
  output logic                      b_ready_o,
  input  logic                      ld_issue_i,
  input  logic [GPR_ADDR_WIDTH-1:0] ld_rd_i,
  input  logic [GPR_ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic [GPR_ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic [GPR_ADDR_WIDTH-1:0] dec_rd_i,
  input  logic                      dec_rs1_use_i,
  input  logic                      dec_rs2_use_i,
  input  logic                      dec_rd_use_i,
  output logic                      hazard_o,
  output logic                      ld_full_o,
  output logic                      wr_en_o,
  output logic [GPR_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [XLEN-1:0]           wr_data_o
);

  localparam int          NREG     = 1 << GPR_ADDR_WIDTH;
  localparam logic [3:0]  LD_MAX_C = 4'(LD_MAX);

  // r_rr_last: port that won the most recent conflict (0 = A, 1 = B).
  logic             r_rr_last;
  logic [NREG-1:0]  r_pending;
  logic [3:0]       r_ld_cnt;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_conflict;
  logic [NREG-1:0]  w_pending_nxt;
  logic [3:0]       w_ld_cnt_nxt;

  // B wins a conflict when A won the previous one.
  assign w_conflict = a_valid_i & b_valid_i;
  assign w_grant_b  = b_valid_i & (~a_valid_i | ~r_rr_last);
  assign w_grant_a  = a_valid_i & ~w_grant_b;

  assign a_ready_o  = w_grant_a;
  assign b_ready_o  = w_grant_b;

  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (w_grant_a) begin
      wr_addr_o = a_addr_i;
      wr_data_o = a_data_i;
      wr_en_o   = (a_addr_i != '0);
    end else if (w_grant_b) begin
      wr_addr_o = b_addr_i;
      wr_data_o = b_data_i;
      wr_en_o   = (b_addr_i != '0);
    end
  end

  // Clear is applied before set so an issue to the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_grant_b)
      w_pending_nxt[b_addr_i] = 1'b0;
    if (ld_issue_i && (ld_rd_i != '0))
      w_pending_nxt[ld_rd_i] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Count saturates at both ends; issue and retire in the same cycle cancel.
  always_comb begin
    w_ld_cnt_nxt = r_ld_cnt;
    if (ld_issue_i && !w_grant_b) begin
      if (r_ld_cnt != LD_MAX_C)
        w_ld_cnt_nxt = r_ld_cnt + 4'd1;
    end else if (w_grant_b && !ld_issue_i) begin
      if (r_ld_cnt != 4'd0)
        w_ld_cnt_nxt = r_ld_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rr_last <= 1'b0;
      r_pending <= '0;
      r_ld_cnt  <= 4'd0;
    end else begin
      if (w_conflict)
        r_rr_last <= w_grant_b;
      r_pending <= w_pending_nxt;
      r_ld_cnt  <= w_ld_cnt_nxt;
    end
  end

  assign ld_full_o = (r_ld_cnt == LD_MAX_C);

  // No same-cycle bypass: a clear lands in r_pending on the next edge.
  assign hazard_o = (dec_rs1_use_i & r_pending[dec_rs1_i]) |
                    (dec_rs2_use_i & r_pending[dec_rs2_i]) |
                    (dec_rd_use_i  & r_pending[dec_rd_i]);

  // An issue while full is only legal if a response retires in the same cycle.
  a_no_issue_when_full : assert property (@(posedge clk_i) disable iff (arst_i)
    !(ld_issue_i && ld_full_o && !w_grant_b));

  a_no_resp_when_empty : assert property (@(posedge clk_i) disable iff (arst_i)
    !(w_grant_b && (r_ld_cnt == 4'd0) && !ld_issue_i));

endmodule
